// File: rtl/outputc_pkg.sv
// -----------------------------------------------------------------------------
// outputc_pkg
// Shared router definitions used by the output-port controller: flit/VC/port
// widths, flit-type field position and encodings, enable/disable levels, the
// controller state type and small helpers.
// -----------------------------------------------------------------------------
package outputc_pkg;

    localparam int unsigned DATAW    = 31;   // flit is DATAW+1 bits
    localparam int unsigned VCHW     = 1;    // VC tag is VCHW+1 bits
    localparam int unsigned VCH      = 1;    // VCH+1 virtual channels
    localparam int unsigned PORTW    = 2;    // port index is PORTW+1 bits
    localparam int unsigned TYPE_MSB = 31;
    localparam int unsigned TYPE_LSB = 30;
    localparam int unsigned NPORT    = 5;

    localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_HEAD     = 2'b00;
    localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_BODY     = 2'b01;
    localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_TAIL     = 2'b10;
    localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_HEADTAIL = 2'b11;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    typedef logic [DATAW:0]             data_t;
    typedef logic [VCHW:0]              vch_t;
    typedef logic [PORTW:0]             port_t;
    typedef logic [2:0]                 idx_t;
    typedef logic [NPORT-1:0]           vec_t;
    typedef logic [TYPE_MSB-TYPE_LSB:0] ftype_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Extract the flit-type field.
    function automatic ftype_t flit_type(input data_t d);
        return d[TYPE_MSB:TYPE_LSB];
    endfunction

    // Next input index, wrapping at NPORT.
    function automatic idx_t next_idx(input idx_t i);
        return (i == idx_t'(NPORT - 1)) ? idx_t'(0) : i + idx_t'(1);
    endfunction

endpackage

// File: rtl/outc_arb.sv
// -----------------------------------------------------------------------------
// outc_arb
// 5-way arbiter: grants the first requester found when searching upward from
// i_ptr (wrapping). With i_ptr tied to 0 it is a fixed-priority arbiter with
// input 0 highest.
//   i_req  request vector, one bit per input
//   i_ptr  search start index (0..4)
//   o_gnt  one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module outc_arb
    import outputc_pkg::*;
(
    input  logic [NPORT-1:0] i_req,
    input  logic [2:0]       i_ptr,
    output logic [NPORT-1:0] o_gnt
);

    logic [3:0] w_sum;
    logic       w_found;

    // Rotating first-one search starting at i_ptr.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < int'(NPORT); k++) begin
            w_sum = {1'b0, i_ptr} + 4'(k);
            if (w_sum >= 4'(NPORT)) begin
                w_sum = w_sum - 4'(NPORT);
            end
            if (!w_found && i_req[w_sum[2:0]]) begin
                o_gnt[w_sum[2:0]] = 1'b1;
                w_found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/outputc.sv
// -----------------------------------------------------------------------------
// outputc
// Router output-port controller. Arbitrates the five input channels that
// request this port, holds the port for one packet (HEAD..TAIL) and forwards
// accepted flits through a single register stage.
//   clk, rst_            clock, synchronous active-high reset
//   idata_N/ivalid_N     flit and valid from input channel N
//   ivch_N               destination VC of that flit
//   req_N/port_N         channel N requests port port_N
//   grt_N                combinational grant to channel N
//   irdy/ilck            downstream per-VC ready / locked (bit 0 used)
//   odata/ovalid/ovch    registered forwarded flit
// Build option: define OUTPUTC_RR_EN for round-robin arbitration; otherwise
// fixed priority with input 0 highest and no pointer register.
// ROUTERID is carried for debug only.
// -----------------------------------------------------------------------------
module outputc
    import outputc_pkg::*;
#(
    parameter int PORTID   = 0,
    parameter int ROUTERID = 0
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic [DATAW:0] idata_0,
    input  logic [DATAW:0] idata_1,
    input  logic [DATAW:0] idata_2,
    input  logic [DATAW:0] idata_3,
    input  logic [DATAW:0] idata_4,
    input  logic           ivalid_0,
    input  logic           ivalid_1,
    input  logic           ivalid_2,
    input  logic           ivalid_3,
    input  logic           ivalid_4,
    input  logic [VCHW:0]  ivch_0,
    input  logic [VCHW:0]  ivch_1,
    input  logic [VCHW:0]  ivch_2,
    input  logic [VCHW:0]  ivch_3,
    input  logic [VCHW:0]  ivch_4,
    input  logic           req_0,
    input  logic           req_1,
    input  logic           req_2,
    input  logic           req_3,
    input  logic           req_4,
    input  logic [PORTW:0] port_0,
    input  logic [PORTW:0] port_1,
    input  logic [PORTW:0] port_2,
    input  logic [PORTW:0] port_3,
    input  logic [PORTW:0] port_4,
    output logic           grt_0,
    output logic           grt_1,
    output logic           grt_2,
    output logic           grt_3,
    output logic           grt_4,
    input  logic [VCH:0]   irdy,
    input  logic [VCH:0]   ilck,
    output logic [DATAW:0] odata,
    output logic           ovalid,
    output logic [VCHW:0]  ovch
);

    data_t  w_idata [NPORT];
    vch_t   w_ivch  [NPORT];
    vec_t   w_ivalid;
    vec_t   w_elig;
    vec_t   w_arb_req;
    vec_t   w_arb_gnt;
    vec_t   w_grt;
    vec_t   w_acc;
    idx_t   w_ptr;
    idx_t   w_sel_idx;
    data_t  w_sel_data;
    vch_t   w_sel_vch;
    logic   w_any;
    ftype_t w_type;
    logic   w_unused;

    state_t r_state;
    idx_t   r_owner;
    data_t  r_odata;
    logic   r_ovalid;
    vch_t   r_ovch;

    assign w_idata[0] = idata_0;
    assign w_idata[1] = idata_1;
    assign w_idata[2] = idata_2;
    assign w_idata[3] = idata_3;
    assign w_idata[4] = idata_4;
    assign w_ivch[0]  = ivch_0;
    assign w_ivch[1]  = ivch_1;
    assign w_ivch[2]  = ivch_2;
    assign w_ivch[3]  = ivch_3;
    assign w_ivch[4]  = ivch_4;
    assign w_ivalid   = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};

    // Eligible: requesting and addressed to this port.
    assign w_elig = {req_4 && (port_4 == port_t'(PORTID)),
                     req_3 && (port_3 == port_t'(PORTID)),
                     req_2 && (port_2 == port_t'(PORTID)),
                     req_1 && (port_1 == port_t'(PORTID)),
                     req_0 && (port_0 == port_t'(PORTID))};

    // Only upper VC bits and the debug id are not consumed here.
    assign w_unused = ^{irdy[VCH:1], ilck[VCH:1], 32'(ROUTERID)};

`ifdef OUTPUTC_RR_EN
    idx_t r_ptr;
    assign w_ptr = r_ptr;
`else
    assign w_ptr = idx_t'(0);
`endif

    // New allocation needs a ready, unlocked downstream VC 0.
    assign w_arb_req = (irdy[0] && !ilck[0]) ? w_elig : '0;

    outc_arb u_arb (
        .i_req (w_arb_req),
        .i_ptr (w_ptr),
        .o_gnt (w_arb_gnt)
    );

    // Grant: arbiter winner when idle, owner only when busy; none in reset.
    always_comb begin
        w_grt = '0;
        if (!rst_ && irdy[0]) begin
            if (r_state == ST_IDLE) begin
                w_grt = w_arb_gnt;
            end else begin
                w_grt[r_owner] = w_elig[r_owner];
            end
        end
    end

    assign w_acc = w_grt & w_ivalid;
    assign w_any = |w_acc;

    // Mux the accepted flit; zero when nothing is accepted.
    always_comb begin
        w_sel_idx  = '0;
        w_sel_data = '0;
        w_sel_vch  = '0;
        for (int k = 0; k < int'(NPORT); k++) begin
            if (w_acc[k]) begin
                w_sel_idx  = idx_t'(k);
                w_sel_data = w_idata[k];
                w_sel_vch  = w_ivch[k];
            end
        end
    end

    assign w_type = flit_type(w_sel_data);

    // Ownership FSM, output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_odata  <= '0;
            r_ovalid <= Disable;
            r_ovch   <= '0;
`ifdef OUTPUTC_RR_EN
            r_ptr    <= '0;
`endif
        end else begin
            r_ovalid <= w_any ? Enable : Disable;
            r_odata  <= w_sel_data;
            r_ovch   <= w_sel_vch;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        if (w_type == TYPE_HEAD) begin
                            r_state <= ST_BUSY;
                            r_owner <= w_sel_idx;
                        end
`ifdef OUTPUTC_RR_EN
                        r_ptr <= next_idx(w_sel_idx);
`endif
                    end
                end
                ST_BUSY: begin
                    if (w_any && (w_type == TYPE_TAIL)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grt_0  = w_grt[0];
    assign grt_1  = w_grt[1];
    assign grt_2  = w_grt[2];
    assign grt_3  = w_grt[3];
    assign grt_4  = w_grt[4];
    assign odata  = r_odata;
    assign ovalid = r_ovalid;
    assign ovch   = r_ovch;

endmodule

// File: tb/tb_outputc.sv
// -----------------------------------------------------------------------------
// tb_outputc
// Directed bench for outputc (PORTID = 0). A reference model of the port's
// ownership/arbitration rules is checked against the DUT every falling edge,
// and directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_outputc;

    localparam logic [1:0] HEAD = 2'b00;
    localparam logic [1:0] BODY = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam logic [1:0] HT   = 2'b11;
`ifdef OUTPUTC_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_;
    logic [31:0] idata [5];
    logic [1:0]  ivch  [5];
    logic [2:0]  port  [5];
    logic [4:0]  ivalid;
    logic [4:0]  req;
    logic [1:0]  irdy;
    logic [1:0]  ilck;
    logic        grt_0, grt_1, grt_2, grt_3, grt_4;
    logic [31:0] odata;
    logic        ovalid;
    logic [1:0]  ovch;
    logic [4:0]  grt_v;

    int n_pass  = 0;
    int n_total = 0;

    assign grt_v = {grt_4, grt_3, grt_2, grt_1, grt_0};

    always #5 clk = ~clk;

    outputc #(.PORTID(0), .ROUTERID(7)) dut (
        .clk(clk), .rst_(rst_),
        .idata_0(idata[0]), .idata_1(idata[1]), .idata_2(idata[2]),
        .idata_3(idata[3]), .idata_4(idata[4]),
        .ivalid_0(ivalid[0]), .ivalid_1(ivalid[1]), .ivalid_2(ivalid[2]),
        .ivalid_3(ivalid[3]), .ivalid_4(ivalid[4]),
        .ivch_0(ivch[0]), .ivch_1(ivch[1]), .ivch_2(ivch[2]),
        .ivch_3(ivch[3]), .ivch_4(ivch[4]),
        .req_0(req[0]), .req_1(req[1]), .req_2(req[2]),
        .req_3(req[3]), .req_4(req[4]),
        .port_0(port[0]), .port_1(port[1]), .port_2(port[2]),
        .port_3(port[3]), .port_4(port[4]),
        .grt_0(grt_0), .grt_1(grt_1), .grt_2(grt_2),
        .grt_3(grt_3), .grt_4(grt_4),
        .irdy(irdy), .ilck(ilck),
        .odata(odata), .ovalid(ovalid), .ovch(ovch)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int          m_owner = -1;   // -1 = port free
    int          m_ptr   = 0;
    logic [31:0] m_odata = '0;
    logic        m_ovalid = 1'b0;
    logic [1:0]  m_ovch  = '0;

    function automatic bit eligible(input int n);
        return req[n] && (port[n] == 3'd0);
    endfunction

    function automatic logic [4:0] exp_grants();
        logic [4:0] g;
        g = '0;
        if (rst_ || !irdy[0]) return g;
        if (m_owner < 0) begin
            if (ilck[0]) return g;
            for (int k = 0; k < 5; k++) begin
                int n;
                n = (m_ptr + k) % 5;
                if (eligible(n)) begin
                    g[n] = 1'b1;
                    return g;
                end
            end
        end else if (eligible(m_owner)) begin
            g[m_owner] = 1'b1;
        end
        return g;
    endfunction

    always @(negedge clk) begin
        logic [4:0] eg;
        logic [1:0] ty;
        int         win;
        eg = exp_grants();
        chk("model_grant",  32'(grt_v),  32'(eg));
        chk("model_ovalid", 32'(ovalid), 32'(m_ovalid));
        chk("model_odata",  odata,       m_odata);
        chk("model_ovch",   32'(ovch),   32'(m_ovch));
        if (rst_) begin
            m_owner = -1; m_ptr = 0;
            m_odata = '0; m_ovalid = 1'b0; m_ovch = '0;
        end else begin
            win = -1;
            for (int k = 0; k < 5; k++) if (eg[k] && ivalid[k]) win = k;
            if (win >= 0) begin
                m_odata = idata[win]; m_ovalid = 1'b1; m_ovch = ivch[win];
                ty = m_odata[31:30];
                if (m_owner < 0) begin
                    if (ty == HEAD) m_owner = win;
                    if (RR) m_ptr = (win + 1) % 5;
                end else if (ty == TAIL) begin
                    m_owner = -1;
                end
            end else begin
                m_odata = '0; m_ovalid = 1'b0; m_ovch = '0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear();
        req = '0; ivalid = '0; irdy = 2'b11; ilck = 2'b00;
        for (int k = 0; k < 5; k++) begin
            idata[k] = '0; ivch[k] = '0; port[k] = 3'd3;
        end
    endtask

    task automatic send(input int n, input logic [1:0] ty, input logic [29:0] pl, input logic [1:0] vc);
        req[n] = 1'b1; ivalid[n] = 1'b1; port[n] = 3'd0;
        idata[n] = {ty, pl}; ivch[n] = vc;
    endtask

    task automatic drop(input int n);
        req[n] = 1'b0; ivalid[n] = 1'b0;
    endtask

    task automatic do_reset();
        rst_ = 1'b1;
        step();
        rst_ = 1'b0;
    endtask

    initial begin
        logic [4:0] arb_exp [4];
        clear();
        rst_ = 1'b1;
        step();
        step();

        // Reset gates grants; single HEADTAIL on input 2.
        send(2, HT, 30'h55, 2'd1);
        #1 chk("rst_grt", 32'(grt_v), 32'h0);
        chk("rst_ovalid", 32'(ovalid), 32'h0);
        rst_ = 1'b0;
        #1 chk("ht_grt", 32'(grt_v), 32'h04);
        step();
        chk("ht_ovalid", 32'(ovalid), 32'h1);
        chk("ht_odata", odata, 32'hC000_0055);
        chk("ht_ovch", 32'(ovch), 32'h1);
        clear();
        send(3, HT, 30'h3, 2'd0);
        #1 chk("idle_after_ht", 32'(grt_v), 32'h08);
        step();
        clear();
        step();
        chk("idle_ovalid", 32'(ovalid), 32'h0);

        // 4-flit packet on input 1 while input 3 waits.
        do_reset();
        send(1, HEAD, 30'd1, 2'd0);
        send(3, HT, 30'd3, 2'd1);
        #1 chk("pkt_head_grt", 32'(grt_v), 32'h02);
        step();
        chk("pkt_head_out", odata, 32'h0000_0001);
        send(1, BODY, 30'd2, 2'd0);
        #1 chk("pkt_body_grt", 32'(grt_v), 32'h02);
        step();
        drop(1);
        #1 chk("owner_drop_grt", 32'(grt_v), 32'h0);
        step();
        send(1, BODY, 30'd3, 2'd0);
        #1 chk("pkt_body2_grt", 32'(grt_v), 32'h02);
        step();
        send(1, TAIL, 30'd4, 2'd0);
        #1 chk("pkt_tail_grt", 32'(grt_v), 32'h02);
        step();
        drop(1);
        #1 chk("after_tail_grt", 32'(grt_v), 32'h08);
        chk("tail_out", odata, 32'h8000_0004);
        step();
        clear();

        // Inputs 0 and 4 both stream HEADTAIL flits.
        do_reset();
        send(0, HT, 30'd10, 2'd0);
        send(4, HT, 30'd14, 2'd0);
        if (RR) arb_exp = '{5'h01, 5'h10, 5'h01, 5'h10};
        else    arb_exp = '{5'h01, 5'h01, 5'h01, 5'h01};
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("arb_%0d", i), 32'(grt_v), 32'(arb_exp[i]));
            step();
        end
        clear();

        // Downstream not ready for 3 cycles mid-packet.
        do_reset();
        send(2, HEAD, 30'd20, 2'd0);
        #1 chk("stall_head_grt", 32'(grt_v), 32'h04);
        step();
        send(2, BODY, 30'd21, 2'd0);
        irdy = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_grt", 32'(grt_v), 32'h0);
            step();
            chk("stall_ovalid", 32'(ovalid), 32'h0);
        end
        irdy = 2'b11;
        ilck = 2'b01;
        send(0, HT, 30'd30, 2'd0);
        #1 chk("resume_grt", 32'(grt_v), 32'h04);
        step();
        chk("resume_out", odata, 32'h4000_0015);
        send(2, TAIL, 30'd22, 2'd0);
        #1 chk("resume_tail_grt", 32'(grt_v), 32'h04);
        step();
        #1 chk("locked_idle_grt", 32'(grt_v), 32'h0);
        clear();
        step();

        // Reset in the middle of a packet.
        do_reset();
        send(1, HEAD, 30'd40, 2'd0);
        #1 chk("mid_head_grt", 32'(grt_v), 32'h02);
        step();
        rst_ = 1'b1;
        send(1, BODY, 30'd41, 2'd0);
        send(3, HEAD, 30'd43, 2'd1);
        #1 chk("rst_mid_grt", 32'(grt_v), 32'h0);
        step();
        rst_ = 1'b0;
        drop(1);
        #1 chk("post_rst_grt", 32'(grt_v), 32'h08);
        chk("post_rst_ovalid", 32'(ovalid), 32'h0);
        step();
        chk("post_rst_out", odata, 32'h0000_002B);
        chk("post_rst_ovch", 32'(ovch), 32'h1);
        send(3, TAIL, 30'd44, 2'd1);
        step();
        clear();

        // Valid flit addressed elsewhere; locked downstream while idle.
        send(0, HT, 30'd50, 2'd0);
        port[0] = 3'd3;
        #1 chk("wrong_port_grt", 32'(grt_v), 32'h0);
        step();
        chk("wrong_port_ovalid", 32'(ovalid), 32'h0);
        port[0] = 3'd0;
        ilck = 2'b01;
        #1 chk("locked_grt", 32'(grt_v), 32'h0);
        step();
        chk("locked_ovalid", 32'(ovalid), 32'h0);
        clear();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
